imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate generator for the decode stage. It accepts one instruction per cycle over a valid/ready handshake and produces the sign- or zero-extended immediate, PC+immediate, and an illegal-select flag one cycle later. A two-entry skid buffer gives full throughput under back-pressure. It sits between fetch/decode and the ID/EX register, and it adds shift-amount and CSR-immediate modes to the base I/S/B/U/J set.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64
- TAG_W, 5, width of the opaque sideband tag (e.g. rd) carried alongside the instruction

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered
- Instr  in  32  instruction word
- ImmSrc  in  3  immediate format select
- PC  in  XLEN  instruction address
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output holds a result
- out_ready  in  1  downstream accepts
- ImmExt  out  XLEN  extended immediate
- PCImm  out  XLEN  PC + ImmExt, modulo 2^XLEN
- out_illegal  out  1  ImmSrc was unsupported
- out_tag  out  TAG_W  tag for this result

## Operation
- ImmSrc encodings:
  - 000 I: sign-extend Instr[31:20].
  - 001 S: sign-extend {Instr[31:25], Instr[11:7]}.
  - 010 B: sign-extend {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - 011 U: {Instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 100 J: sign-extend {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - 101 shamt: zero-extend Instr[25:20] when XLEN=64, or Instr[24:20] when XLEN=32.
  - 110 zimm: zero-extend Instr[19:15].
  - 111: ImmExt=0 and out_illegal=1.
- PCImm is always computed, including for illegal results, where PCImm=PC.
- Storage consists of a main output register and one skid register, each holding {ImmExt, PCImm, illegal, tag}.
- States:
  - EMPTY (out_valid=0)
  - ONE (main valid, skid empty)
  - FULL (both valid)
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + !out_ready → FULL; the new item goes to skid.
  - ONE + accept + out_ready → ONE; main is replaced.
  - ONE + !accept + out_ready → EMPTY.
  - FULL + out_ready → ONE; skid moves to main. No accept is possible in FULL.
- Definitions:
  - accept = in_valid & in_ready.
  - in_ready = !FULL, driven from a register and never combinationally from out_ready.
- Output ordering is strictly in order; no item is dropped or duplicated.

## Timing
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 per cycle while out_ready=1.
- Reset values: out_valid=0, in_ready=1, and ImmExt, PCImm, out_illegal, out_tag all 0. Reset takes effect immediately on rst_n low, discarding any held items mid-operation.
- First accept is possible in the first cycle after rst_n deasserts.
- Output fields stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and out_ready in ONE: the old item leaves and the new item is visible the next cycle.
- PC wrap: PC=max, Imm=+4 gives PCImm=3.

## Configuration
- IMM_EXT_MODES_EN defined: the 101 (shamt) and 110 (zimm) modes operate as specified above.
- IMM_EXT_MODES_EN undefined: 101 and 110 behave like 111, giving ImmExt=0 and out_illegal=1. Logic for those modes is not synthesised.

## Test plan
- XLEN=64, Instr=0xFFF00093, ImmSrc=000, PC=0x1000 → ImmExt=0xFFFF_FFFF_FFFF_FFFF, PCImm=0xFFF, out_valid one cycle after accept.
- Instr=0xFE000EE3 (beq −4), ImmSrc=010, PC=0x1000 → ImmExt=0xFFFF_FFFF_FFFF_FFFC, PCImm=0xFFC. Repeat with XLEN=32: ImmExt=0xFFFF_FFFC.
- Instr=0x800000B7, ImmSrc=011 → ImmExt=0xFFFF_FFFF_8000_0000 at XLEN=64 and 0x8000_0000 at XLEN=32.
- Instr=0x03F0_9093 (slli 63), ImmSrc=101 → ImmExt=63 with the macro defined. With the macro undefined → ImmExt=0 and out_illegal=1. ImmSrc=111 → out_illegal=1 in both builds.
- Back-pressure: stream 8 instructions with tags 0..7 while out_ready toggles 1,0,0,1,…; in_ready must drop only in FULL, and out_tag must appear as 0..7 in order with no loss.
- Reset mid-stream with stage FULL: assert rst_n low → out_valid=0 and in_ready=1 immediately. No old tags may appear after release.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered immediate generator (I/S/B/U/J, plus shamt/zimm when IMM_EXT_MODES_EN is defined); 1-cycle latency.
// Back-pressure: a main register plus one skid entry; in_ready is registered and drops only when both are full.
module imm_gen_stage #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      Instr,
   input  logic [2:0]       ImmSrc,
   input  logic [XLEN-1:0]  PC,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ImmExt,
   output logic [XLEN-1:0]  PCImm,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc_imm;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } item_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t      state, state_nx;
   item_t       main_q, skid_q, new_item;
   logic        load_main, load_skid, skid_to_main, accept;
   logic [31:0] imm32;
   logic        sext, illegal;
   logic [XLEN-1:0] imm_ext;
   logic        unused_opcode;

   assign unused_opcode = ^Instr[6:0];
   assign accept        = in_valid & in_ready;

   // imm32 is already sign-extended to 32 bits for the signed formats
   always_comb begin
      imm32   = '0;
      sext    = 1'b1;
      illegal = 1'b0;
      case (ImmSrc)
         3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
         3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
         3'b010: imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
         3'b011: imm32 = {Instr[31:12], 12'b0};
         3'b100: imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
`ifdef IMM_EXT_MODES_EN
         3'b101: begin
            sext  = 1'b0;
            imm32 = (XLEN == 64) ? {26'b0, Instr[25:20]} : {27'b0, Instr[24:20]};
         end
         3'b110: begin
            sext  = 1'b0;
            imm32 = {27'b0, Instr[19:15]};
         end
`endif
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      if (sext) imm_ext = XLEN'($signed(imm32));
      else      imm_ext = XLEN'(imm32);
   end

   assign new_item = '{imm: imm_ext, pc_imm: PC + imm_ext, illegal: illegal, tag: in_tag};

   always_comb begin
      state_nx     = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nx  = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && !out_ready) begin
               state_nx  = FULL;
               load_skid = 1'b1;
            end else if (accept) begin
               load_main = 1'b1;
            end else if (out_ready) begin
               state_nx = EMPTY;
            end
         end
         FULL: begin
            if (out_ready) begin
               state_nx     = ONE;
               skid_to_main = 1'b1;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         state    <= state_nx;
         in_ready <= (state_nx != FULL);
         if (load_main)         main_q <= new_item;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= new_item;
      end
   end

   assign out_valid   = (state != EMPTY);
   assign ImmExt      = main_q.imm;
   assign PCImm       = main_q.pc_imm;
   assign out_illegal = main_q.illegal;
   assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: drives a 64-bit and a 32-bit instance in lockstep and
// scoreboards every result against hand-computed vectors.
module tb_imm_gen_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready;
   logic [31:0] Instr;
   logic [2:0]  ImmSrc;
   logic [63:0] PC;
   logic [4:0]  in_tag;

   logic        rdy64, vld64, ill64, rdy32, vld32, ill32;
   logic [63:0] imm64, pcimm64;
   logic [31:0] imm32, pcimm32;
   logic [4:0]  tag64, tag32;

   imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
      .Instr(Instr), .ImmSrc(ImmSrc), .PC(PC), .in_tag(in_tag),
      .out_valid(vld64), .out_ready(out_ready), .ImmExt(imm64), .PCImm(pcimm64),
      .out_illegal(ill64), .out_tag(tag64));

   imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
      .Instr(Instr), .ImmSrc(ImmSrc), .PC(PC[31:0]), .in_tag(in_tag),
      .out_valid(vld32), .out_ready(out_ready), .ImmExt(imm32), .PCImm(pcimm32),
      .out_illegal(ill32), .out_tag(tag32));

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [63:0] pc;
      logic [63:0] imm64;
      logic [63:0] pc64;
      logic [31:0] imm32;
      logic [31:0] pc32;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [63:0] imm64;
      logic [63:0] pc64;
      logic [31:0] imm32;
      logic [31:0] pc32;
      logic        ill;
      logic [4:0]  tag;
   } exp_t;

   localparam int NVEC = 11;
   vec_t tbl [NVEC];
   exp_t sbq [$];
   exp_t cur_exp;

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   bit bp_mode = 1'b0;
   bit saw_full = 1'b0;
   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after a negedge with inputs applied; advances to the next negedge.
   task automatic cycle(output bit acc);
      exp_t e;
      if (bp_mode) out_ready = pat[ncyc % 4];
      ncyc++;
      if (sbq.size() == 2) saw_full = 1'b1;
      check("in_ready64", {63'b0, rdy64}, {63'b0, sbq.size() < 2});
      check("out_valid64", {63'b0, vld64}, {63'b0, sbq.size() != 0});
      check("in_ready32", {63'b0, rdy32}, {63'b0, sbq.size() < 2});
      check("out_valid32", {63'b0, vld32}, {63'b0, sbq.size() != 0});
      if (vld64 && sbq.size() > 0) begin
         e = sbq[0];
         check("imm64", imm64, e.imm64);
         check("pcimm64", pcimm64, e.pc64);
         check("ill64", {63'b0, ill64}, {63'b0, e.ill});
         check("tag64", {59'b0, tag64}, {59'b0, e.tag});
         check("imm32", {32'b0, imm32}, {32'b0, e.imm32});
         check("pcimm32", {32'b0, pcimm32}, {32'b0, e.pc32});
         check("ill32", {63'b0, ill32}, {63'b0, e.ill});
         check("tag32", {59'b0, tag32}, {59'b0, e.tag});
      end
      acc = in_valid && rdy64;
      if (vld64 && out_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (acc) sbq.push_back(cur_exp);
      @(negedge clk);
   endtask

   task automatic apply(input int idx, input logic [4:0] tag);
      Instr    = tbl[idx].instr;
      ImmSrc   = tbl[idx].src;
      PC       = tbl[idx].pc;
      in_tag   = tag;
      in_valid = 1'b1;
      cur_exp  = '{tbl[idx].imm64, tbl[idx].pc64, tbl[idx].imm32, tbl[idx].pc32, tbl[idx].ill, tag};
   endtask

   task automatic send(input int idx, input logic [4:0] tag);
      bit acc;
      int n;
      apply(idx, tag);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         cycle(acc);
         n++;
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bit acc;
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sbq.size() > 0 && n < 20) begin
         cycle(acc);
         n++;
      end
      check("drain_left", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      bit acc;

      tbl[0]  = '{32'hFFF00093, 3'b000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF, 32'hFFFF_FFFF, 32'hFFF, 1'b0};
      tbl[1]  = '{32'hFE000EE3, 3'b010, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC, 32'hFFFF_FFFC, 32'hFFC, 1'b0};
      tbl[2]  = '{32'h800000B7, 3'b011, 64'h1000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_1000, 32'h8000_0000, 32'h8000_1000, 1'b0};
      tbl[3]  = '{32'h120021A3, 3'b001, 64'h1000, 64'h123, 64'h1123, 32'h123, 32'h1123, 1'b0};
      tbl[4]  = '{32'hFFFFF06F, 3'b100, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFE, 32'hFFFF_FFFE, 32'hFFE, 1'b0};
      tbl[5]  = '{32'h12345037, 3'b011, 64'h1000, 64'h1234_5000, 64'h1234_6000, 32'h1234_5000, 32'h1234_6000, 1'b0};
      tbl[6]  = '{32'h00400093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4, 64'h3, 32'h4, 32'h3, 1'b0};
      tbl[7]  = '{32'h00000013, 3'b111, 64'h2000, 64'h0, 64'h2000, 32'h0, 32'h2000, 1'b1};
`ifdef IMM_EXT_MODES_EN
      tbl[8]  = '{32'h03F09093, 3'b101, 64'h1000, 64'd63, 64'h103F, 32'd31, 32'h101F, 1'b0};
      tbl[9]  = '{32'h000AD073, 3'b110, 64'h1000, 64'h15, 64'h1015, 32'h15, 32'h1015, 1'b0};
`else
      tbl[8]  = '{32'h03F09093, 3'b101, 64'h1000, 64'h0, 64'h1000, 32'h0, 32'h1000, 1'b1};
      tbl[9]  = '{32'h000AD073, 3'b110, 64'h1000, 64'h0, 64'h1000, 32'h0, 32'h1000, 1'b1};
`endif
      tbl[10] = '{32'hFFFFFFFF, 3'b111, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h1234_5678_9ABC_DEF0, 32'h0, 32'h9ABC_DEF0, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      Instr     = '0;
      ImmSrc    = '0;
      PC        = '0;
      in_tag    = '0;
      cur_exp   = '{64'h0, 64'h0, 32'h0, 32'h0, 1'b0, 5'h0};

      repeat (3) @(negedge clk);
      check("rst_in_ready", {63'b0, rdy64}, 64'd1);
      check("rst_out_valid", {63'b0, vld64}, 64'd0);
      check("rst_imm", imm64, 64'd0);
      check("rst_pcimm", pcimm64, 64'd0);
      check("rst_ill", {63'b0, ill64}, 64'd0);
      check("rst_tag", {59'b0, tag64}, 64'd0);
      check("rst_in_ready32", {63'b0, rdy32}, 64'd1);
      check("rst_out_valid32", {63'b0, vld32}, 64'd0);
      rst_n = 1'b1;

      // One item at a time: latency and every format
      out_ready = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         send(i, 5'(i));
         drain();
      end

      // Back-to-back stream: one accept per cycle
      start = ncyc;
      for (int i = 0; i < NVEC; i++) send(i, 5'(i + 16));
      check("throughput_cycles", 64'(ncyc - start), 64'(NVEC));
      drain();

      // Back-pressure with out_ready pattern 1,0,0,1
      bp_mode = 1'b1;
      for (int i = 0; i < 8; i++) send(i % NVEC, 5'(i));
      bp_mode = 1'b0;
      drain();
      check("saw_full", {63'b0, saw_full}, 64'd1);

      // Reset while FULL
      out_ready = 1'b0;
      send(0, 5'd20);
      send(1, 5'd21);
      apply(2, 5'd22);
      cycle(acc);
      check("full_blocks", {63'b0, acc}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'b0, vld64}, 64'd0);
      check("arst_in_ready", {63'b0, rdy64}, 64'd1);
      check("arst_tag", {59'b0, tag64}, 64'd0);
      check("arst_imm", imm64, 64'd0);
      check("arst_out_valid32", {63'b0, vld32}, 64'd0);
      sbq.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(3, 5'd30);
      drain();
      repeat (3) cycle(acc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
